edge_frame_sequencer: RTL

Top-level frame controller for the edge-detection pipeline. After a start pulse it sequences the window address counter, a single-port memory bus master and the 3x3 convolution kernel. For each output pixel it fetches 9 window pixels, triggers the kernel and writes the result. It counts output pixels and signals frame completion after (width-2)*(height-2) writes.

---
 rtl/edge_frame_sequencer_if.sv | 35 +++
 rtl/edge_frame_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// edge_frame_sequencer_if
// Single-port memory bus between the edge-frame sequencer (master) and the
// pixel memory (slave). Reads are level requests completed by a one-cycle
// rvalid; writes are level requests completed by a one-cycle wack.
//   bus_ren    master->slave  read request, level
//   bus_wen    master->slave  write request, level
//   bus_addr   master->slave  address (ADDR_W)
//   bus_wdata  master->slave  write data (DATA_W)
//   bus_rdata  slave->master  read data (DATA_W)
//   bus_rvalid slave->master  read data valid, one cycle
//   bus_wack   slave->master  write accepted, one cycle
// -----------------------------------------------------------------------------
interface edge_frame_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
) ();
  logic              bus_ren;
  logic              bus_wen;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rvalid;
  logic              bus_wack;

  modport master (
    output bus_ren, bus_wen, bus_addr, bus_wdata,
    input  bus_rdata, bus_rvalid, bus_wack
  );

  modport slave (
    input  bus_ren, bus_wen, bus_addr, bus_wdata,
    output bus_rdata, bus_rvalid, bus_wack
  );
endinterface

// File: rtl/edge_frame_sequencer.sv
// -----------------------------------------------------------------------------
// edge_frame_sequencer
// Frame controller for the edge-detection pipeline. After i_start it fetches
// the 9 pixels of each 3x3 window through the memory bus, loads them into the
// kernel, starts the kernel, and writes the kernel result back. It finishes
// after (width-2)*(height-2) result writes and pulses o_frame_done.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_start, i_img_width/height  frame start pulse and frame dimensions
//   o_busy, o_frame_done, o_err  status: busy level, done pulse, sticky error
//   o_inc_raddr / i_r_ready / i_raddr   read side of the address counter
//   o_inc_waddr / i_w_ready / i_waddr   write side of the address counter
//   bus                          memory bus master (edge_frame_sequencer_if)
//   o_win_data/idx/valid         window pixel load towards the kernel
//   o_kern_start / i_kern_done / i_kern_result   kernel handshake
//
// Optional feature (macro SEQ_TIMEOUT_EN): a watchdog aborts the frame when
// any wait state lasts TIMEOUT cycles, sets sticky o_err and returns to IDLE
// without o_frame_done. Without the macro waits are unbounded, o_err is 0.
// All outputs are registered.
// -----------------------------------------------------------------------------
module edge_frame_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [15:0]       i_img_width,
  input  logic [15:0]       i_img_height,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err,
  output logic              o_inc_raddr,
  output logic              o_inc_waddr,
  input  logic              i_r_ready,
  input  logic              i_w_ready,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [ADDR_W-1:0] i_waddr,
  edge_frame_sequencer_if.master bus,
  output logic [DATA_W-1:0] o_win_data,
  output logic [3:0]        o_win_idx,
  output logic              o_win_valid,
  output logic              o_kern_start,
  input  logic              i_kern_done,
  input  logic [DATA_W-1:0] i_kern_result
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_R_REQ  = 4'd1;
  localparam logic [3:0] S_R_WAIT = 4'd2;
  localparam logic [3:0] S_R_BUS  = 4'd3;
  localparam logic [3:0] S_R_NEXT = 4'd4;
  localparam logic [3:0] S_KSTART = 4'd5;
  localparam logic [3:0] S_KWAIT  = 4'd6;
  localparam logic [3:0] S_W_REQ  = 4'd7;
  localparam logic [3:0] S_W_WAIT = 4'd8;
  localparam logic [3:0] S_W_BUS  = 4'd9;
  localparam logic [3:0] S_W_NEXT = 4'd10;
  localparam logic [3:0] S_DONE   = 4'd11;

  logic [3:0]        state_q,      state_d;
  logic              busy_q,       busy_d;
  logic              frame_done_q, frame_done_d;
  logic              inc_raddr_q,  inc_raddr_d;
  logic              inc_waddr_q,  inc_waddr_d;
  logic              ren_q,        ren_d;
  logic              wen_q,        wen_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic [DATA_W-1:0] win_data_q,   win_data_d;
  logic [3:0]        win_idx_q,    win_idx_d;
  logic              win_valid_q,  win_valid_d;
  logic              kern_start_q, kern_start_d;
  logic [31:0]       count_q,      count_d;
  logic [31:0]       total_q,      total_d;

  logic        small_frame_s;
  logic [31:0] frame_total_s;
  logic [31:0] count_inc_s;

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  // The wait that has lasted TIMEOUT-1 cycles trips on its next edge,
  // so o_err becomes visible exactly TIMEOUT cycles after state entry.
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  logic            err_q, err_d;
  logic [WD_W-1:0] wd_q,  wd_d;
  logic            wait_state_s;
`endif

  // Frame size decode; 32-bit arithmetic so 16-bit dimensions never wrap.
  always_comb begin
    small_frame_s = (i_img_width < 16'd3) || (i_img_height < 16'd3);
    frame_total_s = ({16'd0, i_img_width} - 32'd2) * ({16'd0, i_img_height} - 32'd2);
    count_inc_s   = count_q + 32'd1;
  end

  // Next-state and next-output logic of the frame sequencer.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    inc_raddr_d  = 1'b0;
    inc_waddr_d  = 1'b0;
    ren_d        = ren_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    win_data_d   = win_data_q;
    win_idx_d    = win_idx_q;
    win_valid_d  = 1'b0;
    kern_start_d = 1'b0;
    count_d      = count_q;
    total_d      = total_q;
`ifdef SEQ_TIMEOUT_EN
    err_d        = err_q;
    wd_d         = '0;
    wait_state_s = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          busy_d    = 1'b1;
          total_d   = frame_total_s;
          count_d   = 32'd0;
          win_idx_d = 4'd0;
`ifdef SEQ_TIMEOUT_EN
          err_d     = 1'b0;
`endif
          if (small_frame_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_R_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_R_REQ: begin
        inc_raddr_d = 1'b1;
        state_d     = S_R_WAIT;
      end
      S_R_WAIT: begin
        if (i_r_ready) begin
          addr_d  = i_raddr;
          ren_d   = 1'b1;
          state_d = S_R_BUS;
        end else begin
          state_d = S_R_WAIT;
        end
      end
      S_R_BUS: begin
        if (i_bus_rvalid_s()) begin
          ren_d       = 1'b0;
          win_data_d  = bus.bus_rdata;
          win_valid_d = 1'b1;
          state_d     = S_R_NEXT;
        end else begin
          state_d = S_R_BUS;
        end
      end
      S_R_NEXT: begin
        if (win_idx_q == 4'd8) begin
          win_idx_d = 4'd0;
          state_d   = S_KSTART;
        end else begin
          win_idx_d = win_idx_q + 4'd1;
          state_d   = S_R_REQ;
        end
      end
      S_KSTART: begin
        kern_start_d = 1'b1;
        state_d      = S_KWAIT;
      end
      S_KWAIT: begin
        if (i_kern_done) begin
          wdata_d = i_kern_result;
          state_d = S_W_REQ;
        end else begin
          state_d = S_KWAIT;
        end
      end
      S_W_REQ: begin
        inc_waddr_d = 1'b1;
        state_d     = S_W_WAIT;
      end
      S_W_WAIT: begin
        if (i_w_ready) begin
          addr_d  = i_waddr;
          wen_d   = 1'b1;
          state_d = S_W_BUS;
        end else begin
          state_d = S_W_WAIT;
        end
      end
      S_W_BUS: begin
        if (bus.bus_wack) begin
          wen_d   = 1'b0;
          state_d = S_W_NEXT;
        end else begin
          state_d = S_W_BUS;
        end
      end
      S_W_NEXT: begin
        count_d = count_inc_s;
        if (count_inc_s == total_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_R_REQ;
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

`ifdef SEQ_TIMEOUT_EN
    wait_state_s = (state_q == S_R_WAIT) || (state_q == S_R_BUS) ||
                   (state_q == S_KWAIT)  || (state_q == S_W_WAIT) ||
                   (state_q == S_W_BUS);
    // The counter only runs while a wait state is held; any transition
    // (including the awaited event arriving) restarts it from zero.
    if (wait_state_s && (state_d == state_q)) begin
      if (wd_q == WD_LIMIT) begin
        ren_d     = 1'b0;
        wen_d     = 1'b0;
        err_d     = 1'b1;
        busy_d    = 1'b0;
        win_idx_d = 4'd0;
        state_d   = S_IDLE;
        wd_d      = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end else begin
      wd_d = '0;
    end
`endif
  end

  // Read-valid qualifier kept as a function so the FSM reads uniformly.
  function automatic logic i_bus_rvalid_s();
    return bus.bus_rvalid;
  endfunction

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      inc_raddr_q  <= 1'b0;
      inc_waddr_q  <= 1'b0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      win_data_q   <= '0;
      win_idx_q    <= 4'd0;
      win_valid_q  <= 1'b0;
      kern_start_q <= 1'b0;
      count_q      <= 32'd0;
      total_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      inc_raddr_q  <= inc_raddr_d;
      inc_waddr_q  <= inc_waddr_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      win_data_q   <= win_data_d;
      win_idx_q    <= win_idx_d;
      win_valid_q  <= win_valid_d;
      kern_start_q <= kern_start_d;
      count_q      <= count_d;
      total_q      <= total_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      wd_q  <= '0;
    end else begin
      err_q <= err_d;
      wd_q  <= wd_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_busy        = busy_q;
  assign o_frame_done  = frame_done_q;
  assign o_inc_raddr   = inc_raddr_q;
  assign o_inc_waddr   = inc_waddr_q;
  assign bus.bus_ren   = ren_q;
  assign bus.bus_wen   = wen_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign o_win_data    = win_data_q;
  assign o_win_idx     = win_idx_q;
  assign o_win_valid   = win_valid_q;
  assign o_kern_start  = kern_start_q;

endmodule
